line_sequencer: RTL
===================

Name: line_sequencer

Overview:
- Command-side controller that drives a line_drawer instance and forwards its pixel stream to the VGA framebuffer write port.
- Accepts line commands (endpoints plus colour) over a valid/ready handshake.
- For each command it loads the drawer, counts the exact number of pixels, asserts a write strobe per pixel, then signals completion.
- Sits between the animation/top-level logic and the drawer/VGA framebuffer.

Parameters:
- SCREEN_W, 640, framebuffer width in pixels (clear sweep x range 0..SCREEN_W-1)
- SCREEN_H, 480, framebuffer height in pixels (clear sweep y range 0..SCREEN_H-1)

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  block can accept a command (high only in IDLE)
- cmd_x0, cmd_x1  input  10  line endpoint x coordinates
- cmd_y0, cmd_y1  input  9  line endpoint y coordinates
- cmd_color  input  1  pixel colour (1 = draw, 0 = erase)
- cmd_clear  input  1  command is a full-screen clear; endpoints ignored
- drw_reset  output  1  drives the drawer's reset
- drw_x0, drw_x1  output  10  endpoints to the drawer
- drw_y0, drw_y1  output  9  endpoints to the drawer
- drw_x  input  10  drawer pixel x
- drw_y  input  9  drawer pixel y
- pixel_x  output  10  framebuffer write x
- pixel_y  output  9  framebuffer write y
- pixel_color  output  1  framebuffer write colour
- pixel_write  output  1  framebuffer write enable
- busy  output  1  a command is in progress
- done  output  1  one-cycle pulse when a command completes

Behaviour:
- One clock domain. Synchronous active-high reset.
- Reset values: state IDLE; cmd_ready 1; busy 0; done 0; pixel_write 0; drw_reset 1; all drw_* endpoints 0; pixel_color 0; pixel counter 0.
- Handshake: a command is accepted on a clk edge where cmd_valid && cmd_ready. All command fields are registered at acceptance.
- cmd_ready is high only in IDLE and is combinationally equal to (state == IDLE).
- IDLE:
  - drw_reset = 1, pixel_write = 0.
  - On accept with cmd_clear = 0: go to LOAD, and register count = max(|x1-x0|, |y1-y0|) + 1.
  - The count is an 11-bit unsigned value computed at acceptance; range 1..640.
  - On accept with cmd_clear = 1: go to CLEAR (see Optional Feature).
- LOAD (exactly 1 cycle):
  - drw_reset = 1 and drw_* hold the registered endpoints, so the drawer latches its start point.
  - Next state is DRAW.
- DRAW (exactly count cycles):
  - drw_reset = 0.
  - pixel_write = 1, with pixel_x = drw_x, pixel_y = drw_y, pixel_color = registered colour (combinational pass-through).
  - The counter decrements each cycle. When the counter reaches 1, the next state is DONE.
- DONE (1 cycle): done = 1, pixel_write = 0, drw_reset = 1. Next state is IDLE.
  - A new command can therefore be accepted no earlier than the cycle after done.
- busy = 1 in LOAD, DRAW, CLEAR and DONE.
- drw_* endpoints stay stable from LOAD through DONE.
- Degenerate lines:
  - Single point (x0 == x1, y0 == y1): count = 1, exactly one write.
  - Horizontal, vertical and 45-degree lines need no special case.
- Reset mid-operation: the next edge returns the block to IDLE. pixel_write drops in that cycle; no done pulse is issued.
- cmd_valid asserted outside IDLE is ignored; no fields are sampled.

Optional Feature:
- Macro: LINE_SEQ_CLEAR_EN.
- When defined:
  - cmd_clear = 1 enters CLEAR.
  - Internal x/y counters sweep y = 0..SCREEN_H-1 (outer) and x = 0..SCREEN_W-1 (inner), one pixel per cycle.
  - pixel_write = 1, pixel_color = 0, drw_reset = 1 throughout.
  - After pixel (SCREEN_W-1, SCREEN_H-1) the next state is DONE.
  - Total write cycles = SCREEN_W*SCREEN_H.
- When not defined: cmd_clear is ignored, and every command is treated as a line command.

Test Plan:
- Horizontal line (0,3)->(15,3), colour 1 -> accept; LOAD 1 cycle; 16 consecutive writes x = 0..15, y = 3; done pulse on the next cycle; cmd_ready high the cycle after that.
- Steep negative line (0,27)->(7,3) -> exactly 25 writes; first (7,3), last (0,27); y increments by 1 per write; x is monotonic non-increasing.
- Single point (5,5)->(5,5) -> exactly 1 write at (5,5); done 2 cycles after LOAD.
- Back-to-back: cmd_valid held high with two commands ((1,0)->(27,9), then (1,9)->(27,0), colour 0) -> the second is accepted only in the IDLE cycle after done; each produces 27 writes; second pixel_color = 0.
- Reset asserted during write 5 of (0,0)->(15,15) -> pixel_write 0 on the next cycle; no done pulse; cmd_ready 1; a following command draws normally.
- With LINE_SEQ_CLEAR_EN, SCREEN_W = 8, SCREEN_H = 4, cmd_clear = 1 -> 32 writes in raster order (0,0)..(7,3); colour 0; then done.
  - Without the macro, the same command draws the line given by its endpoints.

Source files
------------

// File: rtl/line_sequencer.sv
// -----------------------------------------------------------------------------
// line_sequencer
//
// Command-side controller for a line_drawer. Accepts a line command over a
// valid/ready handshake, loads the drawer, forwards exactly
// max(|dx|,|dy|)+1 drawer pixels to the framebuffer write port, then pulses
// done for one cycle.
//
// Optional feature (macro LINE_SEQ_CLEAR_EN): a command with cmd_clear = 1
// sweeps the whole framebuffer in raster order with colour 0. Without the
// macro, cmd_clear is ignored and every command is drawn as a line.
//
// Parameters:
//   SCREEN_W, SCREEN_H : framebuffer size used by the clear sweep
//
// Ports:
//   clk, reset                 : clock, synchronous active-high reset
//   cmd_valid / cmd_ready      : command handshake (ready only in IDLE)
//   cmd_x0/y0/x1/y1, cmd_color : line endpoints and pixel colour
//   cmd_clear                  : full-screen clear request
//   drw_reset, drw_x0..drw_y1  : drawer control and endpoints
//   drw_x, drw_y               : current drawer pixel
//   pixel_x/y/color/write      : framebuffer write port
//   busy, done                 : command in progress / completion pulse
// -----------------------------------------------------------------------------
module line_sequencer #(
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [9:0] cmd_x0,
  input  logic [9:0] cmd_x1,
  input  logic [8:0] cmd_y0,
  input  logic [8:0] cmd_y1,
  input  logic       cmd_color,
  input  logic       cmd_clear,
  output logic       drw_reset,
  output logic [9:0] drw_x0,
  output logic [9:0] drw_x1,
  output logic [8:0] drw_y0,
  output logic [8:0] drw_y1,
  input  logic [9:0] drw_x,
  input  logic [8:0] drw_y,
  output logic [9:0] pixel_x,
  output logic [8:0] pixel_y,
  output logic       pixel_color,
  output logic       pixel_write,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_DRAW  = 3'd2,
    ST_CLEAR = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t      state_r;
  state_t      state_s;
  logic [9:0]  x0_r;
  logic [9:0]  x1_r;
  logic [8:0]  y0_r;
  logic [8:0]  y1_r;
  logic        color_r;
  logic [10:0] count_r;
  logic        accept_s;
  logic        clear_req_s;
  logic        clear_last_s;
  logic [9:0]  clr_x_s;
  logic [8:0]  clr_y_s;

  // Pixel count of a Bresenham line: the longer axis span plus one.
  function automatic logic [10:0] line_len(input logic [9:0] ax0, input logic [9:0] ax1,
                                           input logic [8:0] ay0, input logic [8:0] ay1);
    logic [9:0] dx;
    logic [8:0] dy;
    dx = (ax1 >= ax0) ? (ax1 - ax0) : (ax0 - ax1);
    dy = (ay1 >= ay0) ? (ay1 - ay0) : (ay0 - ay1);
    if ({1'b0, dy} > dx) begin
      line_len = {2'b00, dy} + 11'd1;
    end else begin
      line_len = {1'b0, dx} + 11'd1;
    end
  endfunction

  assign cmd_ready = (state_r == ST_IDLE);
  assign accept_s  = cmd_valid && (state_r == ST_IDLE);

  assign drw_x0 = x0_r;
  assign drw_x1 = x1_r;
  assign drw_y0 = y0_r;
  assign drw_y1 = y1_r;

`ifdef LINE_SEQ_CLEAR_EN
  logic [9:0] clr_x_r;
  logic [8:0] clr_y_r;

  assign clear_req_s  = cmd_clear;
  assign clear_last_s = (clr_x_r == 10'(SCREEN_W - 1)) && (clr_y_r == 9'(SCREEN_H - 1));
  assign clr_x_s      = clr_x_r;
  assign clr_y_s      = clr_y_r;

  // Raster sweep counters: x is the inner loop, y the outer one.
  always_ff @(posedge clk) begin
    if (reset) begin
      clr_x_r <= 10'd0;
      clr_y_r <= 9'd0;
    end else if (accept_s) begin
      clr_x_r <= 10'd0;
      clr_y_r <= 9'd0;
    end else if (state_r == ST_CLEAR) begin
      if (clr_x_r == 10'(SCREEN_W - 1)) begin
        clr_x_r <= 10'd0;
        clr_y_r <= clr_y_r + 9'd1;
      end else begin
        clr_x_r <= clr_x_r + 10'd1;
      end
    end
  end
`else
  // Clear support compiled out: the request and screen size go unused.
  localparam int unused_dims_lp = SCREEN_W * SCREEN_H;
  logic unused_clear_s;

  assign unused_clear_s = cmd_clear;
  assign clear_req_s    = 1'b0;
  assign clear_last_s   = 1'b1;
  assign clr_x_s        = 10'd0;
  assign clr_y_s        = 9'd0;
`endif

  // State register, command capture and per-line pixel countdown.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
      x0_r    <= 10'd0;
      x1_r    <= 10'd0;
      y0_r    <= 9'd0;
      y1_r    <= 9'd0;
      color_r <= 1'b0;
      count_r <= 11'd0;
    end else begin
      state_r <= state_s;
      if (accept_s) begin
        x0_r    <= cmd_x0;
        x1_r    <= cmd_x1;
        y0_r    <= cmd_y0;
        y1_r    <= cmd_y1;
        color_r <= cmd_color;
        count_r <= line_len(cmd_x0, cmd_x1, cmd_y0, cmd_y1);
      end else if (state_r == ST_DRAW) begin
        count_r <= count_r - 11'd1;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          if (clear_req_s) begin
            state_s = ST_CLEAR;
          end else begin
            state_s = ST_LOAD;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LOAD: state_s = ST_DRAW;
      ST_DRAW: begin
        // count_r holds the writes still to do, including this cycle's.
        if (count_r == 11'd1) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_DRAW;
        end
      end
      ST_CLEAR: begin
        if (clear_last_s) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_CLEAR;
        end
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // Output decode; pixel data passes straight through from the drawer.
  always_comb begin
    drw_reset   = 1'b1;
    pixel_write = 1'b0;
    pixel_x     = 10'd0;
    pixel_y     = 9'd0;
    pixel_color = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;
    case (state_r)
      ST_IDLE: busy = 1'b0;
      ST_LOAD: busy = 1'b1;
      ST_DRAW: begin
        drw_reset   = 1'b0;
        pixel_write = 1'b1;
        pixel_x     = drw_x;
        pixel_y     = drw_y;
        pixel_color = color_r;
      end
      ST_CLEAR: begin
        pixel_write = 1'b1;
        pixel_x     = clr_x_s;
        pixel_y     = clr_y_s;
      end
      ST_DONE: done = 1'b1;
      default: busy = 1'b0;
    endcase
  end

endmodule
